// File: rtl/disp_page_sched.sv
// Page scheduler for led_disp: time/date page select, blank gap, set-mode blink.
// Define DISP_AUTO_ROTATE_EN to build idle-mode auto-rotation between pages.
module disp_page_sched #(
  parameter int unsigned BLINK_HALF  = 12_500_000,
  parameter int unsigned BLANK_CYC   = 1000,
  parameter int unsigned AUTO_TIME_S = 8,
  parameter int unsigned AUTO_DATE_S = 3,
  parameter logic [6:0]  SEG_BLANK   = 7'h00
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [2:0]  i_mode,
  input  logic        i_sec_tick,
  input  logic [1:0]  i_edit_pos,
  input  logic [41:0] i_time_seg,
  input  logic [41:0] i_date_seg,
  output logic [41:0] o_six_digit_seg,
  output logic [5:0]  o_six_dp,
  output logic        o_page
);

  localparam logic [1:0] ST_TIME  = 2'd0;
  localparam logic [1:0] ST_DATE  = 2'd1;
  localparam logic [1:0] ST_BLANK = 2'd2;

  localparam int BK_W = (BLANK_CYC > 1) ? $clog2(BLANK_CYC) : 1;
  localparam int BL_W = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
  localparam logic [BK_W-1:0] BK_LOAD = BK_W'(BLANK_CYC - 1);
  localparam logic [BL_W-1:0] BL_LAST = BL_W'(BLINK_HALF - 1);
  localparam logic [5:0] DATE_DP = 6'b010100;

  logic [1:0]      fsm;
  logic            target;
  logic            tgt_next;
  logic [BK_W-1:0] bk_cnt;
  logic [BL_W-1:0] bl_cnt;
  logic            bl_on;
  logic [1:0]      edit_q;
  logic            auto_tgt;
  logic            showing;
  logic            in_date;
  logic            blink_run;
  logic            edit_chg;
  logic            hide;
  logic [41:0]     shown;

  assign showing = (fsm == ST_TIME) || (fsm == ST_DATE);
  assign in_date = (fsm == ST_DATE);

`ifdef DISP_AUTO_ROTATE_EN
  localparam int unsigned ROT_MAX =
    (AUTO_TIME_S > AUTO_DATE_S) ? AUTO_TIME_S : AUTO_DATE_S;
  localparam int RT_W = (ROT_MAX > 1) ? $clog2(ROT_MAX) : 1;
  localparam logic [RT_W-1:0] T_LAST = RT_W'(AUTO_TIME_S - 1);
  localparam logic [RT_W-1:0] D_LAST = RT_W'(AUTO_DATE_S - 1);

  logic [2:0]      mode_q;
  logic            rot_tgt;
  logic [RT_W-1:0] rot_cnt;
  logic            idle;
  logic            entering;
  logic [RT_W-1:0] rot_last;

  assign idle     = (i_mode == 3'b000);
  assign entering = idle && (mode_q != 3'b000);
  assign rot_last = in_date ? D_LAST : T_LAST;
  assign auto_tgt = entering ? 1'b0 : rot_tgt;

  // Seconds counter flips the idle target; mode changes take priority
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q  <= 3'b000;
      rot_tgt <= 1'b0;
      rot_cnt <= '0;
    end else begin
      mode_q <= i_mode;
      if (!idle) begin
        rot_cnt <= '0;
      end else if (entering) begin
        rot_tgt <= 1'b0;
        rot_cnt <= '0;
      end else if (i_sec_tick && showing) begin
        if (rot_cnt == rot_last) begin
          rot_tgt <= ~rot_tgt;
          rot_cnt <= '0;
        end else begin
          rot_cnt <= rot_cnt + 1'b1;
        end
      end
    end
  end
`else
  logic unused;
  assign unused   = &{1'b0, i_sec_tick, AUTO_TIME_S[0], AUTO_DATE_S[0]};
  assign auto_tgt = 1'b0;
`endif

  // Requested page from the mode code
  always_comb begin
    tgt_next = target;
    unique case (1'b1)
      i_mode[2]:            tgt_next = i_mode[1];
      (i_mode == 3'b000):   tgt_next = auto_tgt;
      default:              tgt_next = target;
    endcase
  end

  // Page FSM: every page change passes through a blank gap
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm    <= ST_BLANK;
      target <= 1'b0;
      bk_cnt <= BK_LOAD;
      o_page <= 1'b0;
    end else begin
      target <= tgt_next;
      case (fsm)
        ST_TIME, ST_DATE: begin
          if (tgt_next != in_date) begin
            fsm    <= ST_BLANK;
            bk_cnt <= BK_LOAD;
          end
        end
        default: begin
          if (bk_cnt == '0) begin
            fsm    <= tgt_next ? ST_DATE : ST_TIME;
            o_page <= tgt_next;
          end else begin
            bk_cnt <= bk_cnt - 1'b1;
          end
        end
      endcase
    end
  end

  assign blink_run = i_mode[2] && i_mode[0] && (i_edit_pos != 2'd3);
  assign edit_chg  = (i_edit_pos != edit_q);
  assign hide      = blink_run && !edit_chg && !bl_on;

  // Blink phase for the edited pair; restarts visible on a new pair
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bl_cnt <= '0;
      bl_on  <= 1'b1;
      edit_q <= 2'd3;
    end else begin
      edit_q <= i_edit_pos;
      if (!blink_run || edit_chg) begin
        bl_cnt <= '0;
        bl_on  <= 1'b1;
      end else if (bl_cnt == BL_LAST) begin
        bl_cnt <= '0;
        bl_on  <= ~bl_on;
      end else begin
        bl_cnt <= bl_cnt + 1'b1;
      end
    end
  end

  // Selected page with the edited pair blanked in the off phase
  always_comb begin
    shown = in_date ? i_date_seg : i_time_seg;
    if (hide) begin
      case (i_edit_pos)
        2'd0:    shown[13:0]  = {2{SEG_BLANK}};
        2'd1:    shown[27:14] = {2{SEG_BLANK}};
        2'd2:    shown[41:28] = {2{SEG_BLANK}};
        default: shown = shown;
      endcase
    end
  end

  // Registered outputs to led_disp
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_six_digit_seg <= {6{SEG_BLANK}};
      o_six_dp        <= 6'b0;
    end else if (!showing) begin
      o_six_digit_seg <= {6{SEG_BLANK}};
      o_six_dp        <= 6'b0;
    end else begin
      o_six_digit_seg <= shown;
      o_six_dp        <= in_date ? DATE_DP : 6'b0;
    end
  end

endmodule

// File: tb/tb_disp_page_sched.sv
// Bench for disp_page_sched: per-cycle expected outputs queued and compared.
// Rotation scenario follows DISP_AUTO_ROTATE_EN; otherwise idle holds time.
module tb_disp_page_sched;

  typedef struct packed {
    logic [41:0] seg;
    logic [5:0]  dp;
    logic        pg;
  } exp_t;

  localparam logic [41:0] BLK = 42'h0;
  localparam logic [5:0]  DDP = 6'b010100;

  logic        clk;
  logic        rst_n;
  logic [2:0]  mode;
  logic        tick;
  logic [1:0]  edit;
  logic [41:0] tseg;
  logic [41:0] dseg;
  logic [41:0] seg;
  logic [5:0]  dp;
  logic        page;

  exp_t        sb[$];
  int          total;
  int          passed;
  logic [41:0] pat;
  logic [41:0] m0;
  logic [41:0] m1;

  disp_page_sched #(
    .BLINK_HALF(4),
    .BLANK_CYC(3),
    .AUTO_TIME_S(2),
    .AUTO_DATE_S(1),
    .SEG_BLANK(7'h00)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .i_mode(mode),
    .i_sec_tick(tick),
    .i_edit_pos(edit),
    .i_time_seg(tseg),
    .i_date_seg(dseg),
    .o_six_digit_seg(seg),
    .o_six_dp(dp),
    .o_page(page)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  function automatic exp_t mk(logic [41:0] s, logic [5:0] d, logic p);
    exp_t e;
    e.seg = s;
    e.dp  = d;
    e.pg  = p;
    return e;
  endfunction

  task automatic test_reset;
    exp_t e;
    sb.push_back(mk(BLK, 6'b0, 1'b0));
    @(posedge clk);
    #1;
    e = sb.pop_front();
    total++;
    if ({seg, dp, page} !== e)
      $display("FAIL reset_hold: got %h/%b/%b want %h/%b/%b",
               seg, dp, page, e.seg, e.dp, e.pg);
    else passed++;
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      if (i == 1) rst_n = 1'b1;
      sb.push_back(mk((i <= 3) ? BLK : 42'h1, 6'b0, 1'b0));
      @(posedge clk);
      #1;
      e = sb.pop_front();
      total++;
      if ({seg, dp, page} !== e)
        $display("FAIL reset_exit[%0d]: got %h/%b/%b want %h/%b/%b",
                 i, seg, dp, page, e.seg, e.dp, e.pg);
      else passed++;
    end
  endtask

  task automatic test_date;
    exp_t e;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      if (i == 1) mode = 3'b110;
      case (i)
        1:       sb.push_back(mk(42'h1, 6'b0, 1'b0));
        2, 3:    sb.push_back(mk(BLK, 6'b0, 1'b0));
        4:       sb.push_back(mk(BLK, 6'b0, 1'b1));
        default: sb.push_back(mk(42'h2A, DDP, 1'b1));
      endcase
      @(posedge clk);
      #1;
      e = sb.pop_front();
      total++;
      if ({seg, dp, page} !== e)
        $display("FAIL date_page[%0d]: got %h/%b/%b want %h/%b/%b",
                 i, seg, dp, page, e.seg, e.dp, e.pg);
      else passed++;
    end
  endtask

  task automatic test_blink;
    exp_t e;
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      if (i == 1) mode = 3'b100;
      case (i)
        1:       sb.push_back(mk(42'h2A, DDP, 1'b1));
        2, 3:    sb.push_back(mk(BLK, 6'b0, 1'b1));
        4:       sb.push_back(mk(BLK, 6'b0, 1'b0));
        default: sb.push_back(mk(42'h1, 6'b0, 1'b0));
      endcase
      @(posedge clk);
      #1;
      e = sb.pop_front();
      total++;
      if ({seg, dp, page} !== e)
        $display("FAIL back_to_time[%0d]: got %h/%b/%b want %h/%b/%b",
                 i, seg, dp, page, e.seg, e.dp, e.pg);
      else passed++;
    end
    for (int i = 1; i <= 14; i++) begin
      @(negedge clk);
      if (i == 1) begin
        mode = 3'b101;
        edit = 2'd1;
        tseg = pat;
      end
      if (i <= 5 || (((i - 2) / 4) % 2) == 0)
        sb.push_back(mk(pat, 6'b0, 1'b0));
      else
        sb.push_back(mk(m1, 6'b0, 1'b0));
      @(posedge clk);
      #1;
      e = sb.pop_front();
      total++;
      if ({seg, dp, page} !== e)
        $display("FAIL blink_pair1[%0d]: got %h/%b/%b want %h/%b/%b",
                 i, seg, dp, page, e.seg, e.dp, e.pg);
      else passed++;
    end
    for (int j = 1; j <= 8; j++) begin
      @(negedge clk);
      if (j == 1) edit = 2'd0;
      sb.push_back(mk((j <= 5) ? pat : m0, 6'b0, 1'b0));
      @(posedge clk);
      #1;
      e = sb.pop_front();
      total++;
      if ({seg, dp, page} !== e)
        $display("FAIL blink_pair0[%0d]: got %h/%b/%b want %h/%b/%b",
                 j, seg, dp, page, e.seg, e.dp, e.pg);
      else passed++;
    end
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      if (k == 1) begin
        mode = 3'b100;
        edit = 2'd3;
      end
      sb.push_back(mk(pat, 6'b0, 1'b0));
      @(posedge clk);
      #1;
      e = sb.pop_front();
      total++;
      if ({seg, dp, page} !== e)
        $display("FAIL blink_stop[%0d]: got %h/%b/%b want %h/%b/%b",
                 k, seg, dp, page, e.seg, e.dp, e.pg);
      else passed++;
    end
  endtask

`ifdef DISP_AUTO_ROTATE_EN
  task automatic test_rotate;
    exp_t e;
    for (int i = 1; i <= 17; i++) begin
      @(negedge clk);
      if (i == 1) mode = 3'b000;
      tick = (i == 3 || i == 5 || i == 7 || i == 11);
      if (i <= 6 || i >= 16)
        sb.push_back(mk(pat, 6'b0, 1'b0));
      else if (i <= 8 || i == 15)
        sb.push_back(mk(BLK, 6'b0, 1'b0));
      else if (i == 9 || i == 13 || i == 14)
        sb.push_back(mk(BLK, 6'b0, 1'b1));
      else
        sb.push_back(mk(42'h2A, DDP, 1'b1));
      @(posedge clk);
      #1;
      e = sb.pop_front();
      total++;
      if ({seg, dp, page} !== e)
        $display("FAIL rotate[%0d]: got %h/%b/%b want %h/%b/%b",
                 i, seg, dp, page, e.seg, e.dp, e.pg);
      else passed++;
    end
    @(negedge clk);
    tick = 1'b0;
  endtask
`else
  task automatic test_idle_hold;
    exp_t e;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (i == 1) mode = 3'b000;
      tick = (i % 2 == 0);
      sb.push_back(mk(pat, 6'b0, 1'b0));
      @(posedge clk);
      #1;
      e = sb.pop_front();
      total++;
      if ({seg, dp, page} !== e)
        $display("FAIL idle_hold[%0d]: got %h/%b/%b want %h/%b/%b",
                 i, seg, dp, page, e.seg, e.dp, e.pg);
      else passed++;
    end
    @(negedge clk);
    tick = 1'b0;
  endtask
`endif

  task automatic test_mode_vs_rotate;
    exp_t e;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      tick = (i <= 2);
      if (i == 2) mode = 3'b110;
      case (i)
        1, 2:    sb.push_back(mk(pat, 6'b0, 1'b0));
        3, 4:    sb.push_back(mk(BLK, 6'b0, 1'b0));
        5:       sb.push_back(mk(BLK, 6'b0, 1'b1));
        default: sb.push_back(mk(42'h2A, DDP, 1'b1));
      endcase
      @(posedge clk);
      #1;
      e = sb.pop_front();
      total++;
      if ({seg, dp, page} !== e)
        $display("FAIL mode_vs_rot[%0d]: got %h/%b/%b want %h/%b/%b",
                 i, seg, dp, page, e.seg, e.dp, e.pg);
      else passed++;
    end
  endtask

  task automatic test_reset_mid_blank;
    exp_t e;
    for (int i = 1; i <= 2; i++) begin
      @(negedge clk);
      if (i == 1) mode = 3'b100;
      if (i == 1) sb.push_back(mk(42'h2A, DDP, 1'b1));
      else        sb.push_back(mk(BLK, 6'b0, 1'b1));
      @(posedge clk);
      #1;
      e = sb.pop_front();
      total++;
      if ({seg, dp, page} !== e)
        $display("FAIL pre_reset[%0d]: got %h/%b/%b want %h/%b/%b",
                 i, seg, dp, page, e.seg, e.dp, e.pg);
      else passed++;
    end
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    sb.push_back(mk(BLK, 6'b0, 1'b0));
    #1;
    e = sb.pop_front();
    total++;
    if ({seg, dp, page} !== e)
      $display("FAIL async_reset: got %h/%b/%b want %h/%b/%b",
               seg, dp, page, e.seg, e.dp, e.pg);
    else passed++;
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      if (i == 1) rst_n = 1'b1;
      sb.push_back(mk((i <= 3) ? BLK : pat, 6'b0, 1'b0));
      @(posedge clk);
      #1;
      e = sb.pop_front();
      total++;
      if ({seg, dp, page} !== e)
        $display("FAIL post_reset[%0d]: got %h/%b/%b want %h/%b/%b",
                 i, seg, dp, page, e.seg, e.dp, e.pg);
      else passed++;
    end
  endtask

  initial begin
    total  = 0;
    passed = 0;
    rst_n  = 1'b0;
    mode   = 3'b100;
    tick   = 1'b0;
    edit   = 2'd3;
    tseg   = 42'h1;
    dseg   = 42'h2A;
    pat    = {7'h11, 7'h22, 7'h33, 7'h44, 7'h55, 7'h66};
    m1     = {pat[41:28], 14'h0, pat[13:0]};
    m0     = {pat[41:14], 14'h0};
    test_reset();
    test_date();
    test_blink();
`ifdef DISP_AUTO_ROTATE_EN
    test_rotate();
`else
    test_idle_hold();
`endif
    test_mode_vs_rotate();
    test_reset_mid_blank();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
